// File: rtl/mem_scan_led.sv
// Sequential memory scanner: reads an address window over a req/ack bus and
// shows the low byte of each word on the LEDs for a fixed dwell time.
`timescale 1ns/1ps
module mem_scan_led #(
  parameter int                    ADDR_WIDTH    = 64,
  parameter int                    DATA_WIDTH    = 64,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR    = ADDR_WIDTH'(0),
  parameter logic [ADDR_WIDTH-1:0] END_ADDR      = ADDR_WIDTH'(255),
  parameter int                    HOLD_CYCLES   = 30000,
  parameter int                    HOLD_WIDTH    = 20,
  parameter int                    TIMEOUT       = 1023,
  parameter int                    TIMEOUT_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_req_o,
  input  logic                  bus_ack_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_exception_i,
  output logic [7:0]            leds_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DONE, ERR} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic                     req_q, req_d;
  logic [7:0]               leds_q, leds_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic [HOLD_WIDTH-1:0]    holdCnt_q, holdCnt_d;
  logic [TIMEOUT_WIDTH-1:0] timeoutCnt_q, timeoutCnt_d;

  // Only the low byte is displayed; the rest of the word is deliberately dropped.
  logic [DATA_WIDTH-9:0] unusedRdata;
  assign unusedRdata = bus_rdata_i[DATA_WIDTH-1:8];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= START_ADDR;
      req_q        <= 1'b0;
      leds_q       <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      holdCnt_q    <= '0;
      timeoutCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      leds_q       <= leds_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      holdCnt_q    <= holdCnt_d;
      timeoutCnt_q <= timeoutCnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    req_d        = req_q;
    leds_d       = leds_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    holdCnt_d    = holdCnt_q;
    timeoutCnt_d = timeoutCnt_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d      = REQ;
          addr_d       = START_ADDR;
          req_d        = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          timeoutCnt_d = '0;
        end
      end
      REQ: begin
        if (bus_ack_i) begin
          req_d = 1'b0;
          if (bus_exception_i) begin
            busy_d  = 1'b0;
            error_d = 1'b1;
            state_d = ERR;
          end else begin
            leds_d    = bus_rdata_i[7:0];
            holdCnt_d = '0;
            state_d   = HOLD;
          end
        end else if (timeoutCnt_q == TIMEOUT_WIDTH'(TIMEOUT)) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          error_d = 1'b1;
          state_d = ERR;
        end else begin
          timeoutCnt_d = timeoutCnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      HOLD: begin
        // Equality-only termination lets a window with END below START wrap through zero.
        if (holdCnt_q == HOLD_WIDTH'(HOLD_CYCLES - 1)) begin
          if (addr_q == END_ADDR) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            addr_d       = addr_q + ADDR_WIDTH'(1);
            req_d        = 1'b1;
            timeoutCnt_d = '0;
            state_d      = REQ;
          end
        end else begin
          holdCnt_d = holdCnt_q + HOLD_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_addr_o = addr_q;
  assign bus_req_o  = req_q;
  assign leds_o     = leds_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_mem_scan_led.sv
// Directed bench for mem_scan_led: table-driven scans plus hand-written
// sequences for slow ack, exception, timeout, reset and address wrap.
`timescale 1ns/1ps
module tb_mem_scan_led;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct {
    logic [7:0]    addr;
    logic [DW-1:0] rdata;
    logic [7:0]    leds;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start, busAck, busExc;
  logic [DW-1:0] busRdata;
  logic [AW-1:0] busAddr;
  logic          busReq, busy, done, error;
  logic [7:0]    leds;

  logic          wStart, wAck, wExc;
  logic [DW-1:0] wRdata;
  logic [AW-1:0] wAddr;
  logic          wReq, wBusy, wDone, wError;
  logic [7:0]    wLeds;

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  vec_t scanVec[3];
  vec_t wrapVec[4];

  always #5 clk = ~clk;

  mem_scan_led #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(8'h10), .END_ADDR(8'h12),
    .HOLD_CYCLES(4), .HOLD_WIDTH(3), .TIMEOUT(8), .TIMEOUT_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .bus_addr_o(busAddr), .bus_req_o(busReq), .bus_ack_i(busAck),
    .bus_rdata_i(busRdata), .bus_exception_i(busExc),
    .leds_o(leds), .busy_o(busy), .done_o(done), .error_o(error)
  );

  mem_scan_led #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(8'hFE), .END_ADDR(8'h01),
    .HOLD_CYCLES(4), .HOLD_WIDTH(3), .TIMEOUT(8), .TIMEOUT_WIDTH(4)
  ) dutWrap (
    .clk_i(clk), .rst_i(rst), .start_i(wStart),
    .bus_addr_o(wAddr), .bus_req_o(wReq), .bus_ack_i(wAck),
    .bus_rdata_i(wRdata), .bus_exception_i(wExc),
    .leds_o(wLeds), .busy_o(wBusy), .done_o(wDone), .error_o(wError)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else
      passed++;
  endtask

  // Hold req pending for 'delay' cycles, then ack with the given data/exception.
  task automatic applyStimulus(input logic [7:0] expAddr, input logic [DW-1:0] data,
                               input int delay, input logic exc);
    checkOutput("reqHigh", 32'(busReq), 32'd1);
    checkOutput("reqAddr", 32'(busAddr), 32'(expAddr));
    for (int d = 0; d < delay; d++) begin
      tick();
      checkOutput("reqStable", {23'd0, busReq, busAddr}, {23'd0, 1'b1, expAddr});
    end
    busAck   = 1'b1;
    busRdata = data;
    busExc   = exc;
    tick();
    busAck   = 1'b0;
    busExc   = 1'b0;
    busRdata = 16'hDEAD;
    checkOutput("reqDropped", 32'(busReq), 32'd0);
  endtask

  task automatic holdPhase(output int n);
    n = 0;
    while (!busReq && !done && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic runScan(input int slowIdx, input int slowDelay);
    int startCyc;
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    startCyc = cyc;
    checkOutput("scanBusy", 32'(busy), 32'd1);
    checkOutput("scanDoneClr", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(scanVec[i].addr, scanVec[i].rdata, (i == slowIdx) ? slowDelay : 0, 1'b0);
      checkOutput("ledsLatched", 32'(leds), 32'(scanVec[i].leds));
      holdPhase(n);
      checkOutput("holdLen", 32'(n), 32'd4);
      checkOutput("ledsHeld", 32'(leds), 32'(scanVec[i].leds));
    end
    checkOutput("scanDone", 32'(done), 32'd1);
    checkOutput("scanBusyLow", 32'(busy), 32'd0);
    checkOutput("scanNoError", 32'(error), 32'd0);
    checkOutput("scanReqLow", 32'(busReq), 32'd0);
    checkOutput("scanCycles", 32'(cyc - startCyc), 32'(15 + slowDelay));
  endtask

  initial begin
    int n;
    scanVec[0] = '{8'h10, 16'h77A5, 8'hA5};
    scanVec[1] = '{8'h11, 16'h123C, 8'h3C};
    scanVec[2] = '{8'h12, 16'hFF81, 8'h81};
    wrapVec[0] = '{8'hFE, 16'h0011, 8'h11};
    wrapVec[1] = '{8'hFF, 16'h0022, 8'h22};
    wrapVec[2] = '{8'h00, 16'h0033, 8'h33};
    wrapVec[3] = '{8'h01, 16'h0044, 8'h44};

    rst = 1'b1; start = 1'b0; busAck = 1'b0; busExc = 1'b0; busRdata = '0;
    wStart = 1'b0; wAck = 1'b0; wExc = 1'b0; wRdata = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rstLeds", 32'(leds), 32'h00);
    checkOutput("rstReq", 32'(busReq), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstAddr", 32'(busAddr), 32'h10);

    $display("[TB] full scan");
    runScan(-1, 0);

    $display("[TB] slow ack at 0x11");
    runScan(1, 5);

    $display("[TB] exception at 0x11");
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(8'h10, 16'h00A5, 0, 1'b0);
    holdPhase(n);
    checkOutput("excHoldLen", 32'(n), 32'd4);
    applyStimulus(8'h11, 16'h4242, 0, 1'b1);
    checkOutput("excError", 32'(error), 32'd1);
    checkOutput("excBusy", 32'(busy), 32'd0);
    checkOutput("excDone", 32'(done), 32'd0);
    checkOutput("excLeds", 32'(leds), 32'hA5);
    tick();
    tick();
    checkOutput("errSticky", 32'(error), 32'd1);

    $display("[TB] restart then timeout at 0x10");
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restartErrClr", 32'(error), 32'd0);
    checkOutput("restartAddr", 32'(busAddr), 32'h10);
    checkOutput("restartReq", 32'(busReq), 32'd1);
    n = 0;
    while (!error && n < 20) begin
      if (n == 3) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    checkOutput("timeoutCycles", 32'(n), 32'd9);
    checkOutput("timeoutReq", 32'(busReq), 32'd0);
    checkOutput("timeoutBusy", 32'(busy), 32'd0);
    checkOutput("timeoutLeds", 32'(leds), 32'hA5);

    busAck = 1'b1;
    busRdata = 16'h0055;
    tick();
    busAck = 1'b0;
    checkOutput("strayAckLeds", 32'(leds), 32'hA5);
    checkOutput("strayAckErr", 32'(error), 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstErrClr", 32'(error), 32'd0);
    checkOutput("rstErrLeds", 32'(leds), 32'h00);

    $display("[TB] reset mid-scan with ack and start present");
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(8'h10, 16'h00C3, 0, 1'b0);
    checkOutput("midLeds", 32'(leds), 32'hC3);
    holdPhase(n);
    checkOutput("midAddr", 32'(busAddr), 32'h11);
    rst = 1'b1; start = 1'b1; busAck = 1'b1; busRdata = 16'h00EE;
    tick();
    tick();
    rst = 1'b0; start = 1'b0; busAck = 1'b0;
    checkOutput("midRstLeds", 32'(leds), 32'h00);
    checkOutput("midRstReq", 32'(busReq), 32'd0);
    checkOutput("midRstFlags", {29'd0, busy, done, error}, 32'd0);
    checkOutput("midRstAddr", 32'(busAddr), 32'h10);
    tick();
    tick();
    checkOutput("staysIdle", {30'd0, busReq, busy}, 32'd0);

    $display("[TB] address wrap FE..01");
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("wrapReq", 32'(wReq), 32'd1);
      checkOutput("wrapAddr", 32'(wAddr), 32'(wrapVec[i].addr));
      wAck = 1'b1;
      wRdata = wrapVec[i].rdata;
      tick();
      wAck = 1'b0;
      checkOutput("wrapLeds", 32'(wLeds), 32'(wrapVec[i].leds));
      n = 0;
      while (!wReq && !wDone && n < 10) begin
        tick();
        n++;
      end
      checkOutput("wrapHoldLen", 32'(n), 32'd4);
    end
    checkOutput("wrapDone", 32'(wDone), 32'd1);
    checkOutput("wrapBusy", 32'(wBusy), 32'd0);
    checkOutput("wrapError", 32'(wError), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_scan_led.md
Name: mem_scan_led

Overview:
- Sequential memory scanner that sits on the consumer side of data_bus and replaces the free-running address counter in the top level.
- Walks an address window, issues one read per address over a req/ack handshake, and latches the low byte of each word onto the LEDs for a programmable dwell time.
- Flags completion, and flags bus exceptions or timeouts.
- Runs entirely in the fast system clock domain; the dwell counter replaces the divided 1 kHz clock.

Parameters:
- ADDR_WIDTH, 64, width of bus_addr.
- DATA_WIDTH, 64, width of bus_rdata.
- START_ADDR, 0, first address read (typically INITIAL_SP from memory_map).
- END_ADDR, 255, last address read (typically MEM_END from memory_map); inclusive.
- HOLD_CYCLES, 30000, clk cycles each byte is displayed; must be >= 1.
- HOLD_WIDTH, 20, width of the dwell counter; 2^HOLD_WIDTH > HOLD_CYCLES.
- TIMEOUT, 1023, maximum cycles in REQ without bus_ack before error.
- TIMEOUT_WIDTH, 10, width of the timeout counter; 2^TIMEOUT_WIDTH > TIMEOUT.

Ports:
- clk  in  1  system clock (25 MHz); all logic on posedge.
- rst  in  1  reset, active-high.
- start  in  1  one-cycle request to begin a scan; ignored while busy=1.
- bus_addr  out  ADDR_WIDTH  read address to data_bus.
- bus_req  out  1  read request; held high until acknowledged.
- bus_ack  in  1  data_bus read complete; bus_rdata and bus_exception are valid in the same cycle.
- bus_rdata  in  DATA_WIDTH  read data.
- bus_exception  in  1  data_bus address fault, qualified by bus_ack.
- leds  out  8  displayed byte.
- busy  out  1  scan in progress.
- done  out  1  last scan completed without error.
- error  out  1  last scan aborted (exception or timeout).

Behaviour:
- Reset: one clock, synchronous, active-high. rst=1 at a posedge forces state IDLE, bus_addr=START_ADDR, bus_req=0, leds=0, busy=0, done=0, error=0, and both counters to 0.
- Mid-operation reset: rst overrides everything, including an ack arriving in the same cycle. Any outstanding request is dropped without waiting.
- All outputs are registered.
- States: IDLE, REQ, HOLD, DONE, ERR.
- IDLE: start=1 -> REQ; bus_addr<=START_ADDR, bus_req<=1, busy<=1, done<=0, error<=0, timeout counter<=0.
- REQ:
  - bus_req=1 and bus_addr stable until bus_ack is sampled high.
  - bus_ack=1 and bus_exception=0: leds<=bus_rdata[7:0], bus_req<=0, dwell counter<=0 -> HOLD.
  - bus_ack=1 and bus_exception=1: bus_req<=0, busy<=0, error<=1, leds unchanged -> ERR.
  - No ack: timeout counter increments. When it equals TIMEOUT with no ack, same actions as exception -> ERR.
  - A TIMEOUT of N allows acks up to N cycles after bus_req rises.
- HOLD:
  - Dwell counter increments each cycle. At count HOLD_CYCLES-1, i.e. after exactly HOLD_CYCLES cycles in HOLD:
  - If bus_addr==END_ADDR: busy<=0, done<=1 -> DONE.
  - Else: bus_addr<=bus_addr+1 (modulo 2^ADDR_WIDTH), bus_req<=1, timeout counter<=0 -> REQ.
  - Termination is by equality only, so END_ADDR<START_ADDR wraps through zero.
- DONE / ERR: leds hold their last value; done/error stay asserted. start=1 restarts exactly as from IDLE (clears done/error on the same edge).
- Latency:
  - start sampled at edge k -> bus_req=1 after edge k.
  - bus_ack sampled at edge m -> leds updated and bus_req=0 after edge m.
  - Per-address period with single-cycle ack = 1 (REQ) + HOLD_CYCLES.
- Handshake:
  - bus_ack while bus_req=0 is ignored.
  - Never more than one outstanding request.
  - A new request is never raised in the cycle an ack is accepted.
- start while busy=1 is ignored. start and rst together: rst wins.

Test Plan (bench parameters: START_ADDR=0x10, END_ADDR=0x12, HOLD_CYCLES=4, TIMEOUT=8, ADDR_WIDTH=8):
- Reset: rst high 2 cycles mid-scan -> next cycle leds=0, bus_req=0, busy=0, done=0, error=0, bus_addr=0x10.
- Full scan: pulse start; model acks 1 cycle after each req with rdata=0xA5,0x3C,0x81 -> leds sequence A5,3C,81. Each byte held 4 cycles. Addresses 0x10,0x11,0x12. done=1, busy=0 after the last hold. Total 15 cycles from start to done (3 x (1 req + 4 hold)).
- Slow ack: ack delayed 5 cycles at 0x11 -> bus_req and bus_addr=0x11 stable throughout. Ack accepted, no error, scan completes.
- Exception: bus_exception=1 with the ack at 0x11 -> error=1, busy=0, bus_req=0, leds remain 0xA5. A later start rescans from 0x10 with error cleared.
- Timeout: no ack at 0x10 -> error=1 after 9 cycles in REQ. Start pulsed during the scan is ignored.
- Wrap: START_ADDR=0xFE, END_ADDR=0x01 -> addresses FE,FF,00,01, then done=1.
